// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, streams 16-bit words from synchronous
// program memory to the decoder, handles stalls (1-entry skid) and branches.
// Optional FETCH_HALT_EN: opcode 5'b11111 stops fetch until reset.
module fetch_unit #(
    parameter int PC_WIDTH          = 8,
    parameter int PROGRAM_DataWidth = 16,
    parameter int NumOpCodeBits     = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         cnt_wr_en,
    input  logic [PC_WIDTH-1:0]          literal_adr,
    output logic [PC_WIDTH-1:0]          mem_addr,
    output logic                         mem_rd_en,
    input  logic [PROGRAM_DataWidth-1:0] mem_data,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    output logic                         instr_valid,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         halted
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH
`ifdef FETCH_HALT_EN
        , HALT
`endif
    } state_t;

`ifdef FETCH_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    state_t                         state;
    logic [PC_WIDTH-1:0]            fetch_pc;
    logic [PC_WIDTH-1:0]            rd_addr;
    logic                           rd_pending;
    logic                           skid_valid;
    logic [PROGRAM_DataWidth-1:0]   skid_data;
    logic [PC_WIDTH-1:0]            skid_addr;
    logic [NumOpCodeBits-1:0]       opcode;
    logic                           consumed;
    logic                           branch;
    logic                           halt_hit;

    assign consumed  = instr_valid && !stall;
    assign branch    = cnt_wr_en && consumed;
    assign opcode    = instruction[PROGRAM_DataWidth-1 -: NumOpCodeBits];
    assign halt_hit  = HaltEn && consumed && (opcode == '1);
    assign mem_rd_en = (state == FETCH) && !stall;
    assign mem_addr  = branch ? literal_adr : fetch_pc;

`ifndef FETCH_HALT_EN
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= '0;
            rd_addr     <= '0;
            rd_pending  <= 1'b0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_addr   <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
`ifdef FETCH_HALT_EN
            halted      <= 1'b0;
`endif
        end else begin
            if (state == IDLE)
                state <= FETCH;
            if (mem_rd_en) begin
                fetch_pc <= mem_addr + 1'b1;
                rd_addr  <= mem_addr;
            end
            rd_pending <= mem_rd_en;

            if (halt_hit) begin
                // Anything already in flight belongs to the dead stream.
`ifdef FETCH_HALT_EN
                state  <= HALT;
                halted <= 1'b1;
`endif
                instr_valid <= 1'b0;
                skid_valid  <= 1'b0;
                rd_pending  <= 1'b0;
            end else if (stall) begin
                // No read issues under stall, so the skid can only fill once.
                if (rd_pending) begin
                    skid_valid <= 1'b1;
                    skid_data  <= mem_data;
                    skid_addr  <= rd_addr;
                end
            end else if (branch) begin
                instr_valid <= 1'b0;
                skid_valid  <= 1'b0;
            end else if (skid_valid) begin
                instruction <= skid_data;
                pc          <= skid_addr;
                instr_valid <= 1'b1;
                skid_valid  <= 1'b0;
            end else if (rd_pending) begin
                instruction <= mem_data;
                pc          <= rd_addr;
                instr_valid <= 1'b1;
            end else begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the 8-bit core. It is the producer side of the decoder interface.
- Owns the program counter and reads 16-bit instruction words from synchronous program memory.
- Presents each word to the decoder with a valid flag.
- Accepts the decoder's branch request (cnt_wr_en/literal_adr) to redirect fetch.
- Absorbs pipeline stalls without losing or duplicating words.

Parameters:
PC_WIDTH, 8, program counter and program-memory address width
PROGRAM_DataWidth, 16, instruction word width
NumOpCodeBits, 5, opcode field width at instruction[15:11]

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  downstream not ready; freezes the output registers
cnt_wr_en  input  1  branch request from decoder
literal_adr  input  PC_WIDTH  branch target from decoder
mem_addr  output  PC_WIDTH  program-memory read address (combinational)
mem_rd_en  output  1  program-memory read strobe (combinational)
mem_data  input  PROGRAM_DataWidth  read data, valid the cycle after mem_rd_en
instruction  output  PROGRAM_DataWidth  registered instruction to decoder
instr_valid  output  1  instruction holds a live word
pc  output  PC_WIDTH  address of the current instruction
halted  output  1  fetch stopped (see Optional Feature)

Behaviour:
- Reset values (synchronous):
  - instruction=0 (NOP), instr_valid=0, pc=0, halted=0.
  - Internal fetch_pc=0, rd_pending=0, skid_valid=0, state=IDLE.
- States:
  - IDLE: exactly one cycle after reset deasserts; mem_rd_en=0. Goes to FETCH.
  - FETCH: normal streaming.
  - HALT: reachable only with the optional feature enabled.
- consumed = instr_valid && !stall.
- branch = cnt_wr_en && consumed. cnt_wr_en is ignored while stall=1 or instr_valid=0.
- Read issue:
  - mem_rd_en = (state==FETCH) && !stall.
  - mem_addr = branch ? literal_adr : fetch_pc.
  - On issue, fetch_pc <= mem_addr+1, modulo 2^PC_WIDTH (0xFF wraps to 0x00).
  - rd_pending <= 1 and the issued address is tracked for pc.
- Data return (cycle after issue, when rd_pending=1):
  - stall=0: the output registers load mem_data, the tracked address, and instr_valid=1.
  - stall=1: the word goes into a 1-entry skid buffer.
- Skid buffer:
  - While skid_valid=1 and stall=0, outputs load from the skid and the skid clears. A new read may issue in that same cycle.
  - One entry is sufficient and must never overflow: reads issue only when stall=0.
- stall=1: instruction, pc and instr_valid hold.
- No word returning and stall=0: instr_valid <= 0.
- Branch handling:
  - The successor word arriving in the branch cycle is discarded; any skid contents are discarded.
  - The target word returns next cycle.
  - Exactly one bubble results: instr_valid=0 for one cycle, then pc=literal_adr.
- Simultaneous branch and stall: stall wins, branch ignored.
- Reset mid-operation: the pending read and skid are dropped. Data arriving in the first cycle after reset is never presented.

Optional Feature:
Macro FETCH_HALT_EN.
- Defined:
  - A word with opcode 5'b11111 is presented normally with instr_valid=1.
  - On the edge where it is consumed: state <= HALT, halted <= 1, instr_valid <= 0. Any in-flight read data is discarded.
  - In HALT: mem_rd_en=0 and cnt_wr_en is ignored. Only reset exits HALT.
- Not defined:
  - halted is tied to 0 and the HALT state does not exist.
  - Opcode 5'b11111 streams like any other word.

Test Plan:
1. Stream after reset. Setup: mem[i]={i,i}, reset released, stall=0. Required: first instr_valid 3 cycles after reset deasserts, with pc=0x00, instruction=16'h0000. Then pc=0x01, 0x02, ... on consecutive cycles.
2. Stall. Stimulus: stall high for 3 cycles while pc=0x05. Required: pc, instruction and instr_valid hold for those 3 cycles. Then pc=0x06, 0x07 on consecutive cycles, with no address skipped or repeated.
3. Branch. Stimulus: cnt_wr_en=1, literal_adr=0x3F, stall=0 while pc=0x10. Required: one cycle with instr_valid=0, then pc=0x3F, then 0x40. mem[0x11] is never presented.
4. Wrap-around. Stimulus: branch to 0xFE. Required: pc sequence 0xFE, 0xFF, 0x00, 0x01.
5. Reset during stall. Stimulus: stall=1 with the skid full, then reset pulses for 1 cycle. Required: instr_valid=0 and pc=0x00 next cycle, restart from address 0x00. The stale word never appears.
6. Halt. Setup: mem[0x03]=16'hF800.
   - With FETCH_HALT_EN: pc=0x03 is presented valid, then halted=1, instr_valid=0 and mem_rd_en=0 for 20+ cycles.
   - Without FETCH_HALT_EN: pc=0x04 follows and halted stays 0.
